// File: rtl/seq_mul_hs.sv
// Shift-add multiplier, one multiplier bit per clock, start/busy/done handshake.
// Define SEQ_MUL_SIGNED_EN to add radix-2 Booth signed multiply via signed_mode.
module seq_mul_hs #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   multiplicand,
  input  logic           signed_mode,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state, state_nx;
  logic [N:0]     hi, hi_nx;
  logic [N:0]     m, m_nx;
  logic [N:0]     t;
  logic [N-1:0]   lo, lo_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [2*N-1:0] product_nx;
  logic           accept;

`ifdef SEQ_MUL_SIGNED_EN
  logic q_1, q_1_nx;
  logic sgn, sgn_nx;
`else
  logic sign_unused;
  assign sign_unused = signed_mode;
`endif

  assign busy   = (state == CALC);
  assign done   = (state == DONE);
  assign accept = start && (state != CALC);

  always_comb begin
    state_nx   = state;
    hi_nx      = hi;
    lo_nx      = lo;
    m_nx       = m;
    cnt_nx     = cnt;
    product_nx = product;
    t          = hi;
`ifdef SEQ_MUL_SIGNED_EN
    q_1_nx     = q_1;
    sgn_nx     = sgn;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nx = CALC;
          hi_nx    = '0;
          lo_nx    = multiplier;
          cnt_nx   = '0;
`ifdef SEQ_MUL_SIGNED_EN
          m_nx     = {signed_mode & multiplicand[N-1], multiplicand};
          q_1_nx   = 1'b0;
          sgn_nx   = signed_mode;
`else
          m_nx     = {1'b0, multiplicand};
`endif
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
`ifdef SEQ_MUL_SIGNED_EN
        if (sgn) begin
          unique case ({lo[0], q_1})
            2'b10:   t = hi - m;
            2'b01:   t = hi + m;
            default: t = hi;
          endcase
          hi_nx  = {t[N], t[N:1]};
          q_1_nx = lo[0];
        end else begin
          if (lo[0]) t = hi + m;
          hi_nx = {1'b0, t[N:1]};
        end
`else
        if (lo[0]) t = hi + m;
        hi_nx = {1'b0, t[N:1]};
`endif
        lo_nx  = {t[0], lo[N-1:1]};
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_nx   = DONE;
          product_nx = {hi_nx[N-1:0], lo_nx};
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      q_1     <= 1'b0;
      sgn     <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
      m       <= m_nx;
      cnt     <= cnt_nx;
      product <= product_nx;
`ifdef SEQ_MUL_SIGNED_EN
      q_1     <= q_1_nx;
      sgn     <= sgn_nx;
`endif
    end
  end

endmodule

// File: tb/tb_seq_mul_hs.sv
// Scoreboard bench for seq_mul_hs: random and corner multiplies vs an
// arithmetic reference; checks product, latency, busy length, reset abort.
module tb_seq_mul_hs;

  localparam int N = 8;
`ifdef SEQ_MUL_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   multiplier = '0;
  logic [N-1:0]   multiplicand = '0;
  logic           signed_mode = 1'b0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  seq_mul_hs #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .signed_mode  (signed_mode),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [2*N-1:0] prod;
    int             c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   busy_cnt = 0;

  function automatic logic [2*N-1:0] ref_mul(
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic         s
  );
    logic [2*N-1:0] xa, xb;
    if (SGN && s) begin
      xa = {{N{a[N-1]}}, a};
      xb = {{N{b[N-1]}}, b};
    end else begin
      xa = {{N{1'b0}}, a};
      xb = {{N{1'b0}}, b};
    end
    return xa * xb;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", longint'(product), longint'(e.prod));
          check("latency", longint'(cyc - e.c), longint'(N + 1));
          check("busy_cycles", longint'(busy_cnt), longint'(N));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic         s,
    input bit           hold
  );
    int w = 0;
    exp_t e;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      checks++;
      fails++;
      $display("FAIL busy_timeout: got busy=1 expected 0");
    end
    multiplier   = a;
    multiplicand = b;
    signed_mode  = s;
    start        = 1'b1;
    e.prod = ref_mul(a, b, s);
    e.c    = cyc;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
    multiplier   = N'($urandom);
    multiplicand = N'($urandom);
  endtask

  initial begin
    int w;
    #1;
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_product", longint'(product), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'd255, 8'd255, 1'b0, 1'b0);
    issue(8'd0, 8'd173, 1'b0, 1'b0);
    issue(8'hFD, 8'h05, 1'b1, 1'b0);
    issue(8'h80, 8'h80, 1'b1, 1'b0);
    issue(8'd127, 8'h80, 1'b1, 1'b0);

    issue(8'd25, 8'd3, 1'b0, 1'b0);
    @(negedge clk);
    multiplier   = 8'd7;
    multiplicand = 8'd7;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;

    issue(8'd200, 8'd2, 1'b0, 1'b1);
    issue(8'd9, 8'd9, 1'b0, 1'b0);

    issue(8'd5, 8'd6, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_product", longint'(product), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd13, 8'd11, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(0, 12)) @(negedge clk);
      end
    end
    start = 1'b0;

    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (N + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_mul_hs.md
# seq_mul_hs

Parametrised sequential shift-add multiplier producing a full 2N-bit product with a start/busy/done handshake and asynchronous active-low reset. Processes one multiplier bit per clock, so an N×N multiply takes N compute cycles with a single N+1-bit adder. It sits beside the datapath as a shared multi-cycle multiply unit. Optionally supports signed (two's-complement) operands via radix-2 Booth recoding.

## Interface
- N, default 32, operand width in bits. Legal range is N ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only when busy=0.
- multiplier  input  N  operand A. Sampled on the accepting edge.
- multiplicand  input  N  operand B. Sampled on the accepting edge.
- signed_mode  input  1  selects a two's-complement multiply. Sampled on the accepting edge. Ignored unless SEQ_MUL_SIGNED_EN is defined.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse; product is valid from this cycle.
- product  output  2N  result. Held until the next accepted start.

## Operation
- FSM has three states: IDLE, CALC and DONE.
- **Reset** (rst_n=0, asynchronous):
  - state goes to IDLE.
  - busy=0, done=0, product=0.
  - All internal registers are cleared: hi, lo, m, q_1, cnt.
- **Accept:** an edge with start=1 and state ∈ {IDLE, DONE}. It performs:
  - hi ← 0 (N+1 bits)
  - lo ← multiplier
  - m ← multiplicand, zero-extended to N+1 bits (sign-extended in signed mode)
  - q_1 ← 0
  - cnt ← 0
  - state ← CALC
- **Start while in CALC:** ignored entirely. The operands are not re-sampled.
- **Unsigned iteration** (per CALC edge):
  - t = lo[0] ? hi + m : hi, computed at N+1 bits. The carry is kept in t[N].
  - {hi, lo} ← {1'b0, t, lo[N-1:1]} truncated, i.e. a logical right shift of the 2N+1-bit concatenation {t, lo}.
- **Signed iteration** (macro defined and signed_mode latched = 1):
  - Booth pair (lo[0], q_1):
    - 10 → t = hi − m
    - 01 → t = hi + m
    - 00 or 11 → t = hi
  - {hi, lo, q_1} ← arithmetic right shift of {t, lo}. The sign is taken from t[N].
- **Counter:** cnt increments each CALC edge.
  - When cnt = N−1, the edge performs the last iteration and sets state ← DONE.
  - The same edge sets product ← {hi[N-1:0], lo}, taking the post-shift values.
- **DONE:** lasts exactly one cycle, then goes to IDLE unless start=1, in which case a new operation is accepted.
- **Outputs:**
  - busy = (state == CALC), registered.
  - done = (state == DONE).
- **Width rules:**
  - The N+1-bit hi never overflows. Unsigned max is (2^N−1)^2 < 2^2N.
  - Signed −2^(N−1) × −2^(N−1) = 2^(2N−2) is representable.
- **Reset mid-operation:** aborts immediately with the reset values above. No done pulse is emitted.

## Timing
- Accepting edge is E0.
  - busy=1 from E0 to E0+N.
  - Iterations occur on edges E0+1 … E0+N.
  - done=1 and product is valid in the cycle after E0+N.
  - done drops at E0+N+1.
- Latency from start to done is N+1 cycles.
- Throughput is one multiply per N+1 cycles when start is held high, because start is re-accepted in the DONE cycle.
- product changes only on the final CALC edge or on reset. It is stable between operations.
- Operands may change freely after E0.

## Configuration
- SEQ_MUL_SIGNED_EN defined:
  - The signed_mode port is honoured.
  - The Booth datapath, q_1 register and subtractor are present.
- SEQ_MUL_SIGNED_EN undefined:
  - Unsigned-only.
  - signed_mode is left unconnected internally.
  - No q_1 register or subtractor is built.
  - Results are always unsigned products.

## Test plan
- **Unsigned max:** N=8, 255 × 255 unsigned → done exactly 9 cycles after start; product=0xFE01; busy high for 8 cycles.
- **Zero operand:** N=8, 0 × 173 → product=0x0000 with the same 9-cycle latency.
- **Signed cases:** N=8, macro defined:
  - −3 × 5 → 0xFFF1
  - −128 × −128 → 0x4000
  - 127 × −128 → 0xC080
  - With macro undefined, 0xFD × 0x05 with signed_mode=1 → 0x04F1.
- **Start while busy:** start 25 × 3, then assert start with 7 × 7 at cycle 3 → ignored; product=75, one done pulse.
- **Back-to-back:** start held high with 200 × 2 then 9 × 9 presented in the done cycle → second accepted there; products 400 then 81; done pulses N+1 cycles apart.
- **Reset mid-operation:** rst_n=0 at cycle 4 of a multiply → busy=0, done=0, product=0 immediately; no done pulse. A new start after release computes correctly.
